// File: rtl/fir_band_sched.sv
`default_nettype none
// ============================================================================
// Module   : fir_band_sched
// Purpose  : Frame scheduler for the equalizer's shared FIR datapath. Each
//            accepted new-sample strobe runs the enabled bands one after the
//            other through a single coefficient ROM and MAC. For every band
//            it issues accumulator clear, sequencing, coefficient address
//            and accumulate enables, then flags band and frame completion.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            valid           - new-sample strobe (single cycle)
//            band_mask       - bands to run, latched when a frame is accepted
//            busy            - frame in progress
//            sequencing      - datapath advances its sample queue (RUN)
//            accum_clr       - clear left/right accumulators
//            accum_en        - accumulate ROM word times sample
//            band            - band being processed (ROM address high part)
//            coef_addr       - coefficient index (ROM address low part)
//            band_done       - pulse: accumulator holds final band result
//            frame_done      - pulse: all enabled bands finished
//            overrun         - pulse: a strobe arrived and was dropped
// Revision : 1.0 - initial release
// ============================================================================
module fir_band_sched #(
  parameter int NUM_BANDS = 4,
  parameter int TAPS      = 1021,
  parameter int ADDR_W    = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid,
  input  logic [NUM_BANDS-1:0]          band_mask,
  output logic                          busy,
  output logic                          sequencing,
  output logic                          accum_clr,
  output logic                          accum_en,
  output logic [$clog2(NUM_BANDS)-1:0]  band,
  output logic [ADDR_W-1:0]             coef_addr,
  output logic                          band_done,
  output logic                          frame_done,
  output logic                          overrun
);

  localparam int                BAND_W   = $clog2(NUM_BANDS);
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_BANDS-1:0] mask_q, mask_d;
  logic [BAND_W-1:0]    band_q, band_d;
  logic [ADDR_W-1:0]    coef_addr_q, coef_addr_d;
  logic                 busy_q, busy_d;
  logic                 sequencing_q, sequencing_d;
  logic                 accum_clr_q, accum_clr_d;
  logic                 accum_en_q, accum_en_d;
  logic                 band_done_q, band_done_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;

  logic                 accept;
  logic [BAND_W-1:0]    first_idx;
  logic [BAND_W-1:0]    next_idx;
  logic                 has_next;

  // Lowest set bit of the incoming mask: first band of a newly accepted frame.
  // Scanning downwards lets the lowest index win.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (band_mask[i]) begin
        first_idx = BAND_W'(i);
      end
    end
  end

  // Lowest enabled band strictly above the current one; none means the
  // current band is the last of the frame.
  always_comb begin
    next_idx = '0;
    has_next = 1'b0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(band_q))) begin
        next_idx = BAND_W'(i);
        has_next = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic. Every output flop is loaded from
  // the state being entered so the outputs line up with the state register.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    band_d       = band_q;
    coef_addr_d  = coef_addr_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    accept       = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept = valid;
      end
      S_CLR: begin
        overrun_d = valid;
        state_d   = S_RUN;
      end
      S_RUN: begin
        overrun_d = valid;
        if (coef_addr_q == LAST_TAP) begin
          state_d = S_DRAIN;
        end else begin
          coef_addr_d = coef_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        overrun_d    = valid;
        state_d      = S_DONE;
        // frame_done must coincide with the last band's DONE cycle.
        frame_done_d = ~has_next;
      end
      S_DONE: begin
        if (has_next) begin
          overrun_d = valid;
          band_d    = next_idx;
          state_d   = S_CLR;
        end else begin
          state_d = S_IDLE;
          accept  = valid;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      mask_d = band_mask;
      if (|band_mask) begin
        band_d  = first_idx;
        state_d = S_CLR;
      end else begin
        // Nothing to run: report an empty frame and stay idle.
        band_d       = '0;
        state_d      = S_IDLE;
        frame_done_d = 1'b1;
      end
    end

    if (state_d == S_CLR) begin
      coef_addr_d = '0;
    end

    busy_d       = (state_d != S_IDLE);
    sequencing_d = (state_d == S_RUN);
    accum_clr_d  = (state_d == S_CLR);
    band_done_d  = (state_d == S_DONE);
    // ROM has one cycle of read latency, so accumulate trails RUN by one.
    accum_en_d   = sequencing_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mask_q       <= '0;
      band_q       <= '0;
      coef_addr_q  <= '0;
      busy_q       <= 1'b0;
      sequencing_q <= 1'b0;
      accum_clr_q  <= 1'b0;
      accum_en_q   <= 1'b0;
      band_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      band_q       <= band_d;
      coef_addr_q  <= coef_addr_d;
      busy_q       <= busy_d;
      sequencing_q <= sequencing_d;
      accum_clr_q  <= accum_clr_d;
      accum_en_q   <= accum_en_d;
      band_done_q  <= band_done_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy       = busy_q;
  assign sequencing = sequencing_q;
  assign accum_clr  = accum_clr_q;
  assign accum_en   = accum_en_q;
  assign band       = band_q;
  assign coef_addr  = coef_addr_q;
  assign band_done  = band_done_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_band_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_band_sched
// Purpose  : Directed self-checking bench for fir_band_sched at default
//            parameters. Each frame is observed cycle by cycle and its event
//            times compared against hand-computed schedules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_band_sched;

  logic       clk;
  logic       rst_n;
  logic       valid;
  logic [3:0] band_mask;
  logic       busy, sequencing, accum_clr, accum_en;
  logic [1:0] band;
  logic [9:0] coef_addr;
  logic       band_done, frame_done, overrun;

  fir_band_sched #(
    .NUM_BANDS (4),
    .TAPS      (1021),
    .ADDR_W    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .band_mask  (band_mask),
    .busy       (busy),
    .sequencing (sequencing),
    .accum_clr  (accum_clr),
    .accum_en   (accum_en),
    .band       (band),
    .coef_addr  (coef_addr),
    .band_done  (band_done),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Event log of the most recent watch() call, times relative to t0.
  int clr_t[$];
  int bd_t[$];
  int bd_band[$];
  int fd_t[$];
  int ov_t[$];
  int en_cnt;
  int busy_cnt;
  int ramp_err;
  int both_err;
  int exp_addr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe valid with mask m at t0, then observe cycles t0+1..t0+n.
  // Extra strobes are driven at cycles inj_a and inj_b; the mask input
  // changes to mchg_val at cycle mchg_k.
  task automatic watch(input int n, input logic [3:0] m, input int inj_a,
                       input int inj_b, input int mchg_k,
                       input logic [3:0] mchg_val);
    clr_t.delete(); bd_t.delete(); bd_band.delete();
    fd_t.delete(); ov_t.delete();
    en_cnt = 0; busy_cnt = 0; ramp_err = 0; both_err = 0; exp_addr = 0;
    band_mask = m;
    valid     = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (accum_clr) begin
        clr_t.push_back(k);
        if (coef_addr != 10'd0) ramp_err++;
        exp_addr = 0;
      end
      if (sequencing) begin
        if (int'(coef_addr) != exp_addr) ramp_err++;
        exp_addr++;
      end
      if (band_done) begin
        bd_t.push_back(k);
        bd_band.push_back(int'(band));
      end
      if (frame_done) fd_t.push_back(k);
      if (overrun)    ov_t.push_back(k);
      if (accum_en)   en_cnt++;
      if (busy)       busy_cnt++;
      if (accum_clr && accum_en) both_err++;
      valid = (k == inj_a) || (k == inj_b);
      if (k == mchg_k) band_mask = mchg_val;
    end
    valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    valid     = 1'b0;
    band_mask = 4'b0000;
    #3;
    check("rst_busy",      int'(busy), 0);
    check("rst_seq",       int'(sequencing), 0);
    check("rst_clr",       int'(accum_clr), 0);
    check("rst_en",        int'(accum_en), 0);
    check("rst_band",      int'(band), 0);
    check("rst_addr",      int'(coef_addr), 0);
    check("rst_dones",     int'({band_done, frame_done, overrun}), 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_busy",     int'(busy), 0);

    // Empty mask: frame_done one cycle after the strobe, nothing runs.
    watch(6, 4'b0000, -1, -1, -1, 4'b0000);
    check("empty_fd_n",    fd_t.size(), 1);
    check("empty_fd_t",    qget(fd_t, 0), 1);
    check("empty_bd_n",    bd_t.size(), 0);
    check("empty_busy",    busy_cnt, 0);
    check("empty_clr_n",   clr_t.size(), 0);

    // Full frame, overrun at 500, mask change at 10, back-to-back at 4096.
    watch(5130, 4'b1111, 500, 4096, 10, 4'b0001);
    check("full_clr_n",    clr_t.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_clr_t%0d", i), qget(clr_t, i), 1 + 1024 * i);
      check($sformatf("full_bd_t%0d", i),  qget(bd_t, i), 1024 * (i + 1));
      check($sformatf("full_bd_b%0d", i),  qget(bd_band, i), (i < 4) ? i : 0);
    end
    check("full_bd_n",     bd_t.size(), 5);
    check("full_fd_n",     fd_t.size(), 2);
    check("full_fd_t0",    qget(fd_t, 0), 4096);
    check("full_fd_t1",    qget(fd_t, 1), 5120);
    check("full_ov_n",     ov_t.size(), 1);
    check("full_ov_t",     qget(ov_t, 0), 501);
    check("full_en_cnt",   en_cnt, 5 * 1021);
    check("full_ramp",     ramp_err, 0);
    check("full_clr_en",   both_err, 0);
    check("full_busy",     busy_cnt, 5120);

    // Sparse mask: bands 1 and 3 only.
    watch(2060, 4'b1010, -1, -1, -1, 4'b0000);
    check("sp_clr_n",      clr_t.size(), 2);
    check("sp_bd_n",       bd_t.size(), 2);
    check("sp_bd_t0",      qget(bd_t, 0), 1024);
    check("sp_bd_b0",      qget(bd_band, 0), 1);
    check("sp_bd_t1",      qget(bd_t, 1), 2048);
    check("sp_bd_b1",      qget(bd_band, 1), 3);
    check("sp_fd_n",       fd_t.size(), 1);
    check("sp_fd_t",       qget(fd_t, 0), 2048);
    check("sp_en_cnt",     en_cnt, 2 * 1021);
    check("sp_busy",       busy_cnt, 2048);
    check("sp_ov_n",       ov_t.size(), 0);

    // Reset during RUN of band 2.
    watch(2100, 4'b1111, -1, -1, -1, 4'b1111);
    check("ar_pre_bd_n",   bd_t.size(), 2);
    check("ar_pre_band",   int'(band), 2);
    check("ar_pre_seq",    int'(sequencing), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy",       int'(busy), 0);
    check("ar_seq",        int'(sequencing), 0);
    check("ar_en",         int'(accum_en), 0);
    check("ar_band",       int'(band), 0);
    check("ar_addr",       int'(coef_addr), 0);
    step(); step();
    check("ar_dones",      int'({band_done, frame_done, overrun}), 0);
    rst_n = 1'b1;
    step();
    check("ar_idle_dones", int'({band_done, frame_done, busy}), 0);
    watch(1030, 4'b1111, -1, -1, -1, 4'b1111);
    check("ar_clr_t0",     qget(clr_t, 0), 1);
    check("ar_bd_t0",      qget(bd_t, 0), 1024);
    check("ar_bd_b0",      qget(bd_band, 0), 0);
    check("ar_fd_n",       fd_t.size(), 0);
    check("ar_ramp",       ramp_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
